muldiv_sequencer: RTL and testbench

Iterative multi-cycle sequencer for the RV64M multiply/divide ops issued from the decode cycle.
- Accepts one operation per start pulse.
- Runs a radix-2 shift-add multiplier or restoring divider over XLEN cycles.
- Raises a stall so fetch-to-decode and decode-to-execute flops hold while busy.
- Returns a registered result with a one-cycle done pulse for the writeback mux.

---
 rtl/muldiv_pkg.sv | 28 ++
 rtl/muldiv_step.sv | 36 +++
 rtl/muldiv_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV64M multiply/divide sequencer.
// Holds the funct3 op encoding, FSM state type and divide fast-path constants.
package muldiv_pkg;

  localparam int XLEN_P = 64;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [XLEN_P-1:0] DIV_ZERO_QUOT = '1;
  localparam logic [XLEN_P-1:0] MIN_SIGNED =
    {1'b1, {(XLEN_P-1){1'b0}}};

endpackage

// File: rtl/muldiv_step.sv
// One combinational radix-2 iteration on the {hi, lo} accumulator pair.
// Ports: is_div selects divide step; hi_i/lo_i/opnd_i in, hi_o/lo_o out.
module muldiv_step #(
  parameter int XLEN = 64
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] hi_i,
  input  logic [XLEN-1:0] lo_i,
  input  logic [XLEN-1:0] opnd_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN:0] sum;
  logic [XLEN:0] sh;
  logic [XLEN:0] diff;

  always_comb begin
    sum  = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opnd_i} : '0);
    sh   = {hi_i, lo_i[XLEN-1]};
    diff = sh - {1'b0, opnd_i};
    hi_o = sum[XLEN:1];
    lo_o = {sum[0], lo_i[XLEN-1:1]};
    if (is_div) begin
      // Remainder stays below the divisor, so the top diff bit is the borrow.
      if (!diff[XLEN]) begin
        hi_o = diff[XLEN-1:0];
        lo_o = {lo_i[XLEN-2:0], 1'b1};
      end else begin
        hi_o = sh[XLEN-1:0];
        lo_o = {lo_i[XLEN-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV64M mul/div sequencer: XLEN-cycle shift-add / restoring divide.
// Ports: clk, rst, start, op, data_in_a/b, flush in; busy, stall, done, result out.
// Optional MULDIV_EARLY_OUT_EN adds zero-operand and a<b unsigned fast paths.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter int FUNCT3_SIZE = 3,
  parameter int COUNT_SIZE  = $clog2(XLEN) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [FUNCT3_SIZE-1:0] op,
  input  logic [XLEN-1:0]        data_in_a,
  input  logic [XLEN-1:0]        data_in_b,
  input  logic                   flush,
  output logic                   busy,
  output logic                   stall,
  output logic                   done,
  output logic [XLEN-1:0]        result
);

  state_t state_q, state_d;
  op_e    op_q, op_d, op_in;
  logic [COUNT_SIZE-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [XLEN-1:0] opnd_q, opnd_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [XLEN-1:0] prev_q, prev_d;
  logic neg_q, neg_d, rneg_q, rneg_d;

  logic a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN-1:0] step_hi, step_lo;
  logic [XLEN-1:0] fin_val;
  logic [2*XLEN-1:0] prod;

  assign op_in = op_e'(op);

  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    unique case (op_in)
      OP_MULH, OP_DIV, OP_REM: begin
        a_sgn = 1'b1;
        b_sgn = 1'b1;
      end
      OP_MULHSU: a_sgn = 1'b1;
      default: ;
    endcase
    a_neg = a_sgn & data_in_a[XLEN-1];
    b_neg = b_sgn & data_in_b[XLEN-1];
    a_mag = a_neg ? -data_in_a : data_in_a;
    b_mag = b_neg ? -data_in_b : data_in_b;
  end

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div (op_q[2]),
    .hi_i   (hi_q),
    .lo_i   (lo_q),
    .opnd_i (opnd_q),
    .hi_o   (step_hi),
    .lo_o   (step_lo)
  );

  // Fast paths preload {hi, lo} as {remainder, quotient} with sign flags
  // cleared, so FIN selects the answer through the normal path.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opnd_d  = opnd_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    unique case (state_q)
      IDLE: begin
        if (start && !flush) begin
          op_d    = op_in;
          cnt_d   = COUNT_SIZE'(XLEN);
          neg_d   = a_neg ^ b_neg;
          rneg_d  = a_neg;
          hi_d    = '0;
          lo_d    = op_in[2] ? a_mag : b_mag;
          opnd_d  = op_in[2] ? b_mag : a_mag;
          state_d = CALC;
          if (op_in[2] && data_in_b == '0) begin
            hi_d    = data_in_a;
            lo_d    = DIV_ZERO_QUOT;
            neg_d   = 1'b0;
            rneg_d  = 1'b0;
            state_d = FIN;
          end else if (op_in[2] && a_sgn &&
                       data_in_a == MIN_SIGNED &&
                       data_in_b == DIV_ZERO_QUOT) begin
            hi_d    = '0;
            lo_d    = data_in_a;
            neg_d   = 1'b0;
            rneg_d  = 1'b0;
            state_d = FIN;
          end
`ifdef MULDIV_EARLY_OUT_EN
          else if (!op_in[2] &&
                   (data_in_a == '0 || data_in_b == '0)) begin
            hi_d    = '0;
            lo_d    = '0;
            neg_d   = 1'b0;
            rneg_d  = 1'b0;
            state_d = FIN;
          end else if ((op_in == OP_DIVU || op_in == OP_REMU) &&
                       data_in_a < data_in_b) begin
            hi_d    = data_in_a;
            lo_d    = '0;
            neg_d   = 1'b0;
            rneg_d  = 1'b0;
            state_d = FIN;
          end
`endif
        end
      end
      CALC: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q - COUNT_SIZE'(1);
        if (flush) state_d = IDLE;
        else if (cnt_q == COUNT_SIZE'(1)) state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    prod = {hi_d, lo_d};
    if (neg_d) prod = -prod;
    if (!op_d[2]) begin
      fin_val = (op_d == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end else if (!op_d[1]) begin
      fin_val = neg_d ? -lo_d : lo_d;
    end else begin
      fin_val = rneg_d ? -hi_d : hi_d;
    end
  end

  // Result loads on entry to FIN so it is valid alongside done; a flush
  // in FIN restores the previous value.
  always_comb begin
    result_d = result_q;
    prev_d   = prev_q;
    if (state_d == FIN && state_q != FIN) begin
      prev_d   = result_q;
      result_d = fin_val;
    end else if (state_q == FIN && flush) begin
      result_d = prev_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= OP_MUL;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
      prev_q   <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
      prev_q   <= prev_d;
    end
  end

  assign busy   = state_q != IDLE;
  assign stall  = (start & (state_q == IDLE) & ~flush) | (state_q == CALC);
  assign done   = (state_q == FIN) & ~flush;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer with a behavioural reference model.
// Directed plan cases, random ops, flush and async reset scenarios.
module tb_muldiv_sequencer;

  localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic        busy, stall, done;
  logic [63:0] result;

  muldiv_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .data_in_a (a),
    .data_in_b (b),
    .flush     (flush),
    .busy      (busy),
    .stall     (stall),
    .done      (done),
    .result    (result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] res;
    int          at;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [63:0] last_exp = '0;

  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] ref_res(logic [2:0] o, logic [63:0] x,
                                          logic [63:0] y);
    logic [127:0] ex, ey, p;
    logic signed [63:0] sx, sy;
    sx = x;
    sy = y;
    ex = {64'd0, x};
    ey = {64'd0, y};
    case (o)
      3'd0: return x * y;
      3'd1: begin
        ex = {{64{x[63]}}, x};
        ey = {{64{y[63]}}, y};
        p = ex * ey;
        return p[127:64];
      end
      3'd2: begin
        ex = {{64{x[63]}}, x};
        p = ex * ey;
        return p[127:64];
      end
      3'd3: begin
        p = ex * ey;
        return p[127:64];
      end
      3'd4: begin
        if (y == 0) return ONES;
        if (x == MINV && y == ONES) return x;
        return sx / sy;
      end
      3'd5: return (y == 0) ? ONES : x / y;
      3'd6: begin
        if (y == 0) return x;
        if (x == MINV && y == ONES) return 64'd0;
        return sx % sy;
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic int ref_lat(logic [2:0] o, logic [63:0] x,
                                 logic [63:0] y);
    if (o[2] && y == 0) return 1;
    if ((o == 3'd4 || o == 3'd6) && x == MINV && y == ONES) return 1;
`ifdef MULDIV_EARLY_OUT_EN
    if (!o[2] && (x == 0 || y == 0)) return 1;
    if ((o == 3'd5 || o == 3'd7) && x < y) return 1;
`endif
    return 65;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected 0 (cycle %0d)",
                 cyc);
      end else begin
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("done_cycle", 64'(cyc), 64'(e.at));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the cycle after done.
  task automatic issue(input logic [2:0] o, input logic [63:0] x,
                       input logic [63:0] y);
    int lat;
    int stalls;
    bit got;
    lat = ref_lat(o, x, y);
    last_exp = ref_res(o, x, y);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    sb.push_back('{last_exp, cyc + lat});
    stalls = 0;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (stall) stalls++;
      if (done) got = 1'b1;
      else begin
        @(posedge clk);
        #1;
        start = (lat > 5 && i == 3);
        op = 3'($urandom);
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done expected done op=%0d", o);
    end
    chk("stall_cycles", 64'(stalls), 64'(lat));
    start = 1'b0;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rand_opnd();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return ONES;
      2: return MINV;
      3: return 64'($urandom_range(0, 20));
      4: return -64'($urandom_range(1, 20));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_result", result, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    issue(3'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD);
    issue(3'd3, ONES, ONES);
    issue(3'd1, ONES, ONES);
    issue(3'd4, 64'd100, 64'd0);
    issue(3'd6, 64'd100, 64'd0);
    issue(3'd4, MINV, ONES);
    issue(3'd6, MINV, ONES);
    issue(3'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
    issue(3'd6, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
    issue(3'd5, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
    issue(3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5);

    for (int n = 0; n < 40; n++) begin
      issue(3'($urandom), rand_opnd(), rand_opnd());
    end

    // Flush a DIVU in CALC at cycle 10.
    start = 1'b1;
    op = 3'd5;
    a = 64'd1000;
    b = 64'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    @(negedge clk);
    chk("flush_done", 64'(done), 64'd0);
    chk("flush_busy_c10", 64'(busy), 64'd1);
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_busy_c11", 64'(busy), 64'd0);
    chk("flush_result", result, last_exp);
    issue(3'd0, 64'd3, 64'd5);

    // start and flush together in IDLE: nothing starts.
    start = 1'b1;
    flush = 1'b1;
    op = 3'd0;
    a = 64'd9;
    b = 64'd9;
    @(negedge clk);
    chk("sf_stall", 64'(stall), 64'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    chk("sf_busy", 64'(busy), 64'd0);

    // Async reset mid-CALC.
    start = 1'b1;
    op = 3'd0;
    a = 64'd11;
    b = 64'd13;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_stall", 64'(stall), 64'd0);
    chk("arst_result", result, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    issue(3'd7, 64'd100, 64'd7);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
